// File: rtl/priority_event_encoder_8to3.sv
// Collects one-hot events into a pending register and serves them
// one at a time, in priority order, as a 3-bit index over valid/ready.
module priority_event_encoder_8to3 #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       clr_ovf,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_pending;
    logic [2:0] r_code;
    logic       r_ovf;

    logic [7:0] w_set_vec;
    logic [7:0] w_clr_vec;
    logic [7:0] w_pend_nxt;
    logic [7:0] w_collide;
    logic       w_any;
    logic       w_valid;
    logic       w_accept;
    logic       w_load;
    logic [2:0] w_sel;

    // Gate incoming requests with the capture enable
    always_comb begin
        w_set_vec = en ? req : 8'h00;
    end

    // Pick the highest-priority bit of the registered pending value only
    always_comb begin
        w_sel = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (r_pending[i]) begin
                    w_sel = 3'(i);
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (r_pending[i]) begin
                    w_sel = 3'(i);
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: reload while work remains, drop to idle when drained
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ready && !w_any) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, load strobe and the bit to retire
    always_comb begin
        w_any     = |r_pending;
        w_valid   = (r_state == ST_SEND);
        w_accept  = w_valid && ready;
        w_load    = ((r_state == ST_IDLE) || w_accept) && w_any;
        w_clr_vec = 8'h00;
        if (w_load) begin
            w_clr_vec = 8'h01 << w_sel;
        end
    end

    // Next pending value; a same-cycle set beats the serve clear
    always_comb begin
        w_pend_nxt = (r_pending & ~w_clr_vec) | w_set_vec;
        w_collide  = w_set_vec & r_pending & ~w_clr_vec;
    end

    // Pending register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 8'h00;
        end else begin
            r_pending <= w_pend_nxt;
        end
    end

    // Code register: only moves on a load, holds through stalls and idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= 3'd0;
        end else if (w_load) begin
            r_code <= w_sel;
        end
    end

    // Sticky overflow; a new collision outranks the clear request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (|w_collide) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign code     = r_code;
    assign valid    = w_valid;
    assign pending  = r_pending;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_priority_event_encoder_8to3.sv
// Bench for priority_event_encoder_8to3: both priority orders side by
// side against a cycle-level reference model plus directed scenarios.
module tb_priority_event_encoder_8to3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       clr_ovf;
    logic       ready;

    logic [2:0] h_code, l_code;
    logic       h_valid, l_valid;
    logic [7:0] h_pend, l_pend;
    logic       h_ovf, l_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    priority_event_encoder_8to3 #(.HIGH_FIRST(1'b1)) dut_h (
        .clk(clk), .rst(rst), .en(en), .req(req), .clr_ovf(clr_ovf),
        .ready(ready), .code(h_code), .valid(h_valid),
        .pending(h_pend), .overflow(h_ovf)
    );

    priority_event_encoder_8to3 #(.HIGH_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .en(en), .req(req), .clr_ovf(clr_ovf),
        .ready(ready), .code(l_code), .valid(l_valid),
        .pending(l_pend), .overflow(l_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = high-first, index 1 = low-first
    logic [7:0] m_pend  [2];
    logic [2:0] m_code  [2];
    logic       m_valid [2];
    logic       m_ovf   [2];
    logic [25:0] exp_vec;
    logic [25:0] obs_vec;

    assign obs_vec = {h_valid, h_code, h_pend, h_ovf,
                      l_valid, l_code, l_pend, l_ovf};

    function automatic int pick(input logic [7:0] p, input bit hf);
        int v;
        int lsb;
        v = int'(p);
        if (hf) return $clog2(v + 1) - 1;
        lsb = v & (-v);
        return $clog2(lsb);
    endfunction

    task automatic mdl_tick(input int k);
        logic [7:0] set;
        logic [7:0] clr;
        int s;
        set = en ? req : 8'h00;
        clr = 8'h00;
        if (rst) begin
            m_pend[k]  = 8'h00;
            m_code[k]  = 3'd0;
            m_valid[k] = 1'b0;
            m_ovf[k]   = 1'b0;
            return;
        end
        if ((!m_valid[k] || ready) && m_pend[k] != 8'h00) begin
            s = pick(m_pend[k], k == 0);
            clr = 8'(1 << s);
            m_code[k]  = 3'(s);
            m_valid[k] = 1'b1;
        end else if (m_valid[k] && ready) begin
            m_valid[k] = 1'b0;
        end
        if ((set & m_pend[k] & ~clr) != 8'h00) m_ovf[k] = 1'b1;
        else if (clr_ovf) m_ovf[k] = 1'b0;
        m_pend[k] = (m_pend[k] & ~clr) | set;
    endtask

    task automatic step();
        @(posedge clk);
        mdl_tick(0);
        mdl_tick(1);
        exp_vec = {m_valid[0], m_code[0], m_pend[0], m_ovf[0],
                   m_valid[1], m_code[1], m_pend[1], m_ovf[1]};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 8'hFF; ready = 1'b1; clr_ovf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({h_pend, h_valid, h_code, h_ovf,
                 l_pend, l_valid, l_code, l_ovf} !== 26'd0)
                $display("FAIL reset_state got h=%h/%b/%0d/%b l=%h/%b/%0d/%b exp all zero",
                         h_pend, h_valid, h_code, h_ovf,
                         l_pend, l_valid, l_code, l_ovf);
            else n_pass++;
        end
        req = 8'h00;
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (obs_vec !== exp_vec)
            $display("FAIL reset_model got %h exp %h", obs_vec, exp_vec);
        else n_pass++;
    endtask

    task automatic test_order();
        logic [11:0] seq_h, seq_l;
        int cnt_h, cnt_l;
        seq_h = '0; seq_l = '0; cnt_h = 0; cnt_l = 0;
        ready = 1'b1;
        req = 8'b1010_0100;
        step();
        req = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step();
            if (h_valid) begin seq_h = {seq_h[8:0], h_code}; cnt_h++; end
            if (l_valid) begin seq_l = {seq_l[8:0], l_code}; cnt_l++; end
            n_checks++;
            if (obs_vec !== exp_vec)
                $display("FAIL order_model cyc %0d got %h exp %h", i, obs_vec, exp_vec);
            else n_pass++;
        end
        n_checks++;
        if (cnt_h !== 3 || seq_h[8:0] !== 9'b111_101_010)
            $display("FAIL order_high got cnt=%0d seq=%o exp cnt=3 seq=752", cnt_h, seq_h[8:0]);
        else n_pass++;
        n_checks++;
        if (cnt_l !== 3 || seq_l[8:0] !== 9'b010_101_111)
            $display("FAIL order_low got cnt=%0d seq=%o exp cnt=3 seq=257", cnt_l, seq_l[8:0]);
        else n_pass++;
        n_checks++;
        if ({h_valid, h_pend, l_valid, l_pend} !== 18'd0)
            $display("FAIL order_drained got hv=%b hp=%h lv=%b lp=%h exp 0",
                     h_valid, h_pend, l_valid, l_pend);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        req = 8'h01;
        step();
        req = 8'h00;
        step();
        for (int i = 0; i < 5; i++) begin
            req = (i == 1) ? 8'h80 : 8'h00;
            step();
            n_checks++;
            if ({h_valid, h_code, l_valid, l_code} !== 8'b1000_1000)
                $display("FAIL stall_hold cyc %0d got h=%b/%0d l=%b/%0d exp 1/0",
                         i, h_valid, h_code, l_valid, l_code);
            else n_pass++;
        end
        req = 8'h00;
        n_checks++;
        if (h_pend !== 8'h80 || l_pend !== 8'h80)
            $display("FAIL stall_pending got h=%h l=%h exp 80", h_pend, l_pend);
        else n_pass++;
        ready = 1'b1;
        step();
        n_checks++;
        if ({h_valid, h_code, l_valid, l_code} !== 8'b1111_1111)
            $display("FAIL stall_release got h=%b/%0d l=%b/%0d exp 1/7",
                     h_valid, h_code, l_valid, l_code);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec)
                $display("FAIL stall_model cyc %0d got %h exp %h", i, obs_vec, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        int served4;
        served4 = 0;
        ready = 1'b0;
        req = 8'h01; step();
        req = 8'h00; step();
        req = 8'h10; step();
        req = 8'h00; step();
        req = 8'h10; step();
        req = 8'h00;
        n_checks++;
        if ({h_ovf, h_pend, l_ovf, l_pend} !== {1'b1, 8'h10, 1'b1, 8'h10})
            $display("FAIL ovf_set got h=%b/%h l=%b/%h exp 1/10",
                     h_ovf, h_pend, l_ovf, l_pend);
        else n_pass++;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (h_valid && h_code == 3'd4) served4++;
        end
        n_checks++;
        if (served4 !== 1)
            $display("FAIL ovf_served_once got %0d exp 1", served4);
        else n_pass++;
        clr_ovf = 1'b1; step();
        clr_ovf = 1'b0;
        n_checks++;
        if (h_ovf !== 1'b0 || l_ovf !== 1'b0)
            $display("FAIL ovf_clear got h=%b l=%b exp 0", h_ovf, l_ovf);
        else n_pass++;
        ready = 1'b0;
        req = 8'h01; step();
        req = 8'h00; step();
        req = 8'h10; step();
        req = 8'h10; clr_ovf = 1'b1; step();
        req = 8'h00; clr_ovf = 1'b0;
        n_checks++;
        if (h_ovf !== 1'b1 || l_ovf !== 1'b1)
            $display("FAIL ovf_set_beats_clr got h=%b l=%b exp 1", h_ovf, l_ovf);
        else n_pass++;
        step();
        n_checks++;
        if (obs_vec !== exp_vec)
            $display("FAIL ovf_model got %h exp %h", obs_vec, exp_vec);
        else n_pass++;
        ready = 1'b1; clr_ovf = 1'b1;
        for (int i = 0; i < 4; i++) step();
        clr_ovf = 1'b0;
        n_checks++;
        if (obs_vec !== exp_vec || h_ovf !== 1'b0 || h_valid !== 1'b0)
            $display("FAIL ovf_drain got %h exp %h", obs_vec, exp_vec);
        else n_pass++;
    endtask

    task automatic test_set_clear();
        ready = 1'b1;
        req = 8'h08; step();
        req = 8'h08; step();
        req = 8'h00;
        n_checks++;
        if ({h_valid, h_code, h_pend, h_ovf} !== {1'b1, 3'd3, 8'h08, 1'b0})
            $display("FAIL setclr_first got v=%b c=%0d p=%h o=%b exp 1/3/08/0",
                     h_valid, h_code, h_pend, h_ovf);
        else n_pass++;
        step();
        n_checks++;
        if ({h_valid, h_code, h_pend, l_valid, l_code} !== {1'b1, 3'd3, 8'h00, 1'b1, 3'd3})
            $display("FAIL setclr_again got h=%b/%0d/%h l=%b/%0d exp 1/3/00",
                     h_valid, h_code, h_pend, l_valid, l_code);
        else n_pass++;
        step();
        n_checks++;
        if (h_valid !== 1'b0 || l_valid !== 1'b0 || obs_vec !== exp_vec)
            $display("FAIL setclr_idle got %h exp %h", obs_vec, exp_vec);
        else n_pass++;
    endtask

    task automatic test_enable();
        en = 1'b0; req = 8'hFF; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({h_pend, h_valid, l_pend, l_valid} !== 18'd0)
                $display("FAIL en_gate cyc %0d got hp=%h hv=%b lp=%h lv=%b exp 0",
                         i, h_pend, h_valid, l_pend, l_valid);
            else n_pass++;
        end
        req = 8'h00; en = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            en      = ($urandom_range(0, 7) != 0);
            req     = 8'($urandom & $urandom & $urandom);
            ready   = ($urandom_range(0, 3) != 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            step();
            n_checks++;
            if (obs_vec !== exp_vec)
                $display("FAIL random cyc %0d got %h exp %h", i, obs_vec, exp_vec);
            else n_pass++;
        end
        rst = 1'b0; req = 8'h00; clr_ovf = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00; clr_ovf = 1'b0; ready = 1'b0;
        test_reset();
        test_order();
        test_backpressure();
        test_overflow();
        test_set_clear();
        test_enable();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/priority_event_encoder_8to3.md
Name: priority_event_encoder_8to3

Overview:
- Sequential counterpart of the 3-to-8 decoder: collects events on 8 one-hot request lines and encodes them back to a 3-bit index.
- Latches each event in a pending register.
- Serves pending events one at a time, in priority order, over a valid/ready handshake.
- Intended as the source side of any path that later drives a 3-to-8 decoder (e.g. interrupt/event index to a select bus).

Parameters:
- HIGH_FIRST, 1, 1 = bit 7 has highest priority; 0 = bit 0 has highest priority.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  capture enable; when 0, req is ignored (pending and output stage keep running)
- req  input  8  event request lines; each bit high for one or more cycles marks event i; sampled every cycle
- clr_ovf  input  1  clears the sticky overflow flag
- ready  input  1  consumer accepts code when valid && ready
- code  output  3  encoded index of the served event
- valid  output  1  code is valid
- pending  output  8  current pending register (observability)
- overflow  output  1  sticky: an event arrived on a bit already pending

Behaviour:
- Reset (rst=1 at a clock edge) forces: pending=8'h00, code=3'd0, valid=0, overflow=0, FSM=IDLE. Reset wins over every other input in the same cycle.
- Capture: set_vec = en ? req : 8'h00. Every edge: pending_next = (pending & ~clr_vec) | set_vec.
  - Set wins: if bit i is cleared and requested in the same cycle, bit i stays 1.
- FSM states:
  - IDLE (valid=0).
  - SEND (valid=1).
- Load condition: load = (state==IDLE || (valid && ready)) && (pending != 0).
- Selection: when load, pick index s of the highest-priority set bit of the registered pending value.
  - Selection never looks at req in the same cycle.
  - HIGH_FIRST=1: highest set index wins. HIGH_FIRST=0: lowest set index wins.
  - On load: code<=s, clr_vec=one-hot(s), state<=SEND. Otherwise clr_vec=0.
- Transitions:
  - IDLE -> SEND on load.
  - SEND, valid && !ready: hold. code and valid must stay stable; pending still accumulates.
  - SEND, valid && ready, pending != 0: reload the next code in the same cycle (back-to-back, one code per cycle).
  - SEND, valid && ready, pending == 0: -> IDLE, valid<=0. code keeps its last value.
- Latency: req bit at edge N -> pending bit set after edge N -> valid/code after edge N+1 (2 cycles), provided the FSM is IDLE.
- A held-high req re-sets its bit every cycle. The bit is therefore served repeatedly; this is intended, and upstream pulses req.
- Overflow:
  - Sets when set_vec[i]=1 while pending[i]=1 and clr_vec[i]=0.
  - Cleared by clr_ovf; set has priority over clr_ovf in the same cycle.
  - The served code itself is never counted as overflow.
- No combinational path from req to code/valid. ready affects state only at the clock edge.
- Reset mid-transfer: valid drops on the next edge; any un-accepted code and all pending events are discarded.

Test Plan:
- rst=1 for 2 cycles with req=8'hFF, en=1 -> pending=0, valid=0, code=0, overflow=0 throughout.
- HIGH_FIRST=1, ready=1, single pulse req=8'b1010_0100 -> valid for 3 consecutive cycles, code=5,2 order preceded by 7 (7,5,2), then valid=0, pending=0.
- HIGH_FIRST=0, same pulse -> codes 2,5,7.
- Backpressure: pulse req=8'h01, ready=0 for 5 cycles -> code=0, valid=1 stable for all 5. Pulse req=8'h80 during the stall -> pending=8'h80; after ready=1, code=7 on the next cycle.
- Overflow: pulse req=8'h10 twice before service (ready=0) -> overflow=1, bit served once. clr_ovf=1 for one cycle -> overflow=0. clr_ovf and a new collision in the same cycle -> overflow stays 1.
- Set/clear collision: pending=8'h08 being loaded while req=8'h08 the same cycle -> code=3 output and pending[3] still 1, so code=3 is served again.
- en=0 with req=8'hFF -> pending unchanged, no new valid.
